// File: rtl/detector_trigger_shaper_if.sv
// rtl/detector_trigger_shaper_if.sv - signal bundle between the calibration FSM side and the trigger shaper
//
// Purpose: groups the trigger shaper's control inputs and status outputs.
// Port summary:
//   enable, trigger_in, detector_ready  -> driven by master, read by the shaper
//   detector_trigger, busy, state_out,
//   trigger_count, dropped_count,
//   timeout_flag                        -> driven by the shaper (slave)
// CNT_W must match the CNT_W of the shaper instance connected to it.

interface detector_trigger_shaper_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             trigger_in;
    logic             detector_ready;
    logic             detector_trigger;
    logic             busy;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] trigger_count;
    logic [15:0]      dropped_count;
    logic             timeout_flag;

    modport master (
        output enable, trigger_in, detector_ready,
        input  detector_trigger, busy, state_out, trigger_count, dropped_count, timeout_flag
    );

    modport slave (
        input  enable, trigger_in, detector_ready,
        output detector_trigger, busy, state_out, trigger_count, dropped_count, timeout_flag
    );
endinterface

// File: rtl/detector_trigger_shaper.sv
// rtl/detector_trigger_shaper.sv - shapes trigger edges into fixed-width detector pulses with dead time
//
// Purpose: a rising edge of trigger_in, accepted in IDLE with enable and a
// synchronized detector_ready, produces a PULSE_WIDTH-cycle detector_trigger,
// followed by a HOLDOFF of at least HOLDOFF cycles that also waits for the
// detector to report ready. Rejected edges are counted in dropped_count.
// Optional feature macro: READY_TIMEOUT_EN (bounds the ready wait by TIMEOUT
// cycles and reports it through the sticky timeout_flag).
// Ports:
//   clock         system clock
//   reset_signal  asynchronous reset, active-low
//   bus           detector_trigger_shaper_if.slave (enable, trigger_in,
//                 detector_ready in; detector_trigger, busy, state_out,
//                 trigger_count, dropped_count, timeout_flag out)

module detector_trigger_shaper #(
    parameter int PULSE_WIDTH = 2000,
    parameter int HOLDOFF     = 1000,
    parameter int TIMEOUT     = 1_400_000,
    parameter int CNT_W       = 32
) (
    input  logic                      clock,
    input  logic                      reset_signal,
    detector_trigger_shaper_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_PULSE   = 2'b01;
    localparam logic [1:0] S_HOLDOFF = 2'b10;

    localparam int MAX_PH  = (PULSE_WIDTH > HOLDOFF) ? PULSE_WIDTH : HOLDOFF;
    localparam int MAX_ALL = (MAX_PH > TIMEOUT) ? MAX_PH : TIMEOUT;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] PW_LOAD = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] HO_LOAD = CW'(HOLDOFF - 1);

    logic             trig_d;
    logic             rdy_meta;
    logic             rdy_s;
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             det_q;
    logic [CNT_W-1:0] tcnt;
    logic [15:0]      dcnt;
    logic             tflag;
    logic             rise;
    logic             accept;

    assign rise   = bus.trigger_in & ~trig_d;
    assign accept = (state == S_IDLE) && rise && bus.enable && rdy_s;

`ifdef READY_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    // Cycles spent in HOLDOFF; cleared on entry, holds once it reaches TO_LAST.
    logic [CW-1:0] wcnt;
`endif

    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            trig_d   <= 1'b0;
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
            state    <= S_IDLE;
            cnt      <= '0;
            det_q    <= 1'b0;
            tcnt     <= '0;
            dcnt     <= '0;
            tflag    <= 1'b0;
`ifdef READY_TIMEOUT_EN
            wcnt     <= '0;
`endif
        end else begin
            trig_d   <= bus.trigger_in;
            rdy_meta <= bus.detector_ready;
            rdy_s    <= rdy_meta;

            // Any edge not turned into a pulse is a drop, including the one
            // landing on the HOLDOFF->IDLE cycle.
            if (rise && !accept && dcnt != 16'hFFFF) begin
                dcnt <= dcnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_PULSE;
                        cnt   <= PW_LOAD;
                        det_q <= 1'b1;
                        tcnt  <= tcnt + CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        state <= S_HOLDOFF;
                        cnt   <= HO_LOAD;
                        det_q <= 1'b0;
`ifdef READY_TIMEOUT_EN
                        wcnt  <= '0;
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (cnt == '0 && rdy_s) begin
                        state <= S_IDLE;
                    end
`ifdef READY_TIMEOUT_EN
                    else if (!rdy_s && wcnt == TO_LAST) begin
                        state <= S_IDLE;
                        tflag <= 1'b1;
                    end
                    if (wcnt != TO_LAST) begin
                        wcnt <= wcnt + CW'(1);
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    det_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.detector_trigger = det_q;
    assign bus.busy             = (state != S_IDLE);
    assign bus.state_out        = state;
    assign bus.trigger_count    = tcnt;
    assign bus.dropped_count    = dcnt;
    assign bus.timeout_flag     = tflag;
endmodule

// File: tb/tb_detector_trigger_shaper.sv
// tb/tb_detector_trigger_shaper.sv - randomized self-checking bench for detector_trigger_shaper
module tb_detector_trigger_shaper;
    localparam int PW = 20;
    localparam int HO = 10;
    localparam int TO = 60;
    localparam int CW = 32;

    logic clock = 1'b0;
    logic reset_signal;
    always #5 clock = ~clock;

    detector_trigger_shaper_if #(.CNT_W(CW)) bus ();

    detector_trigger_shaper #(
        .PULSE_WIDTH(PW), .HOLDOFF(HO), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset_signal(reset_signal),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the edge index at which the current pulse was
    // accepted and derives every output from elapsed edges since then.
    int          cyc;
    int          m_acc;
    bit          m_prev_tin;
    bit          m_rdy_hist1, m_rdy_hist2;
    logic [31:0] m_tcnt;
    int          m_dcnt;
    bit          m_tflag;
    int          run_len;

    bit cur_en, cur_tin, cur_rdy;

    task automatic model_reset();
        m_acc       = -1;
        m_prev_tin  = 1'b0;
        m_rdy_hist1 = 1'b0;
        m_rdy_hist2 = 1'b0;
        m_tcnt      = '0;
        m_dcnt      = 0;
        m_tflag     = 1'b0;
        run_len     = 0;
    endtask

    task automatic drop();
        if (m_dcnt < 65535) m_dcnt++;
    endtask

    task automatic check_all(input string phase);
        bit  e_det, e_busy;
        logic [1:0] e_state;
        e_busy  = (m_acc >= 0);
        e_det   = e_busy && (cyc - 1 < m_acc + PW);
        e_state = !e_busy ? 2'b00 : (e_det ? 2'b01 : 2'b10);
        expect_eq({phase, ".det"},   bus.detector_trigger, e_det);
        expect_eq({phase, ".busy"},  bus.busy, e_busy);
        expect_eq({phase, ".state"}, bus.state_out, e_state);
        expect_eq({phase, ".tcnt"},  bus.trigger_count, m_tcnt);
        expect_eq({phase, ".dcnt"},  bus.dropped_count, m_dcnt);
        expect_eq({phase, ".tflag"}, bus.timeout_flag, m_tflag);
        if (bus.detector_trigger === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            expect_eq({phase, ".width"}, run_len, PW);
            run_len = 0;
        end
    endtask

    // One clock: apply inputs, predict the effect of the coming edge, then
    // sample the DUT at the following falling edge.
    task automatic step(input string phase);
        bit rise, rs;
        bus.enable         = cur_en;
        bus.trigger_in     = cur_tin;
        bus.detector_ready = cur_rdy;
        rs   = m_rdy_hist2;
        rise = cur_tin && !m_prev_tin;
        if (m_acc < 0) begin
            if (rise) begin
                if (cur_en && rs) begin
                    m_acc  = cyc;
                    m_tcnt = m_tcnt + 32'd1;
                end else begin
                    drop();
                end
            end
        end else begin
            if (rise) drop();
            if (cyc >= m_acc + PW + HO && rs) begin
                m_acc = -1;
            end
`ifdef READY_TIMEOUT_EN
            else if (cyc == m_acc + PW + TO && !rs) begin
                m_acc   = -1;
                m_tflag = 1'b1;
            end
`endif
        end
        m_prev_tin  = cur_tin;
        m_rdy_hist2 = m_rdy_hist1;
        m_rdy_hist1 = cur_rdy;
        cyc++;
        @(posedge clock);
        @(negedge clock);
        check_all(phase);
    endtask

    task automatic idle_cycles(input string phase, input int n);
        for (int i = 0; i < n; i++) step(phase);
    endtask

    task automatic pulse_in(input string phase);
        cur_tin = 1'b1;
        step(phase);
        step(phase);
        cur_tin = 1'b0;
        step(phase);
    endtask

    task automatic run_random(input string phase, input int n, input int tin_pct,
                              input int rdy_chg_pct, input int rdy_hi_pct,
                              input int en_chg_pct, input int en_hi_pct);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < tin_pct) cur_tin = ~cur_tin;
            if ($urandom_range(99) < rdy_chg_pct) cur_rdy = ($urandom_range(99) < rdy_hi_pct);
            if ($urandom_range(99) < en_chg_pct) cur_en = ($urandom_range(99) < en_hi_pct);
            step(phase);
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        cur_en = 1'b1; cur_tin = 1'b0; cur_rdy = 1'b1;
        reset_signal       = 1'b0;
        bus.enable         = 1'b1;
        bus.trigger_in     = 1'b0;
        bus.detector_ready = 1'b1;

        // Reset held while trigger_in toggles.
        for (int i = 0; i < 6; i++) begin
            bus.trigger_in = i[0];
            @(posedge clock);
            @(negedge clock);
            expect_eq("rst.det",   bus.detector_trigger, 1'b0);
            expect_eq("rst.state", bus.state_out, 2'b00);
            expect_eq("rst.tcnt",  bus.trigger_count, '0);
            expect_eq("rst.dcnt",  bus.dropped_count, '0);
        end
        bus.trigger_in = 1'b0;
        reset_signal   = 1'b1;
        idle_cycles("post_rst", 5);

        // Single accepted trigger and its full pulse/holdoff.
        pulse_in("single");
        idle_cycles("single", PW + HO + 5);

        // Rises during PULSE/HOLDOFF are drops; next one after IDLE is accepted.
        pulse_in("drops");
        for (int k = 0; k < 3; k++) begin
            idle_cycles("drops", 5);
            pulse_in("drops");
        end
        idle_cycles("drops", PW + HO);
        pulse_in("drops2");
        idle_cycles("drops2", PW + HO + 5);

        // Ready held low well past holdoff (and past TIMEOUT).
        pulse_in("rdy");
        cur_rdy = 1'b0;
        idle_cycles("rdy", PW + HO + TO + 20);
        cur_rdy = 1'b1;
        idle_cycles("rdy", 10);
        pulse_in("rdy_tick");
        cur_rdy = 1'b0;
        idle_cycles("rdy_tick", PW + HO + 5);
        cur_rdy = 1'b1;
        idle_cycles("rdy_tick", TO + 10);

        // Enable low blocks, level held high gives exactly one pulse.
        cur_en = 1'b0;
        pulse_in("en_off");
        cur_en = 1'b1;
        cur_tin = 1'b1;
        idle_cycles("level", 4 * (PW + HO));
        cur_tin = 1'b0;
        idle_cycles("level", 5);

        // Async reset in the middle of a pulse.
        pulse_in("midrst");
        idle_cycles("midrst", 7);
        #2;
        reset_signal = 1'b0;
        #1;
        expect_eq("midrst.det",  bus.detector_trigger, 1'b0);
        expect_eq("midrst.busy", bus.busy, 1'b0);
        expect_eq("midrst.tcnt", bus.trigger_count, '0);
        expect_eq("midrst.dcnt", bus.dropped_count, '0);
        @(negedge clock);
        cur_tin = 1'b0;
        bus.trigger_in = 1'b0;
        reset_signal = 1'b1;
        model_reset();
        idle_cycles("post_midrst", 5);

        // Randomized traffic with varying ready/enable behaviour.
        run_random("rnd_busy",  3000, 30, 2, 90, 2, 90);
        run_random("rnd_rdy",   3000, 10, 3, 50, 1, 95);
        run_random("rnd_en",    3000, 20, 1, 95, 10, 50);
        run_random("rnd_slow",  3000, 2, 1, 30, 1, 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
